// File: rtl/wishbone_master.sv
// wishbone_master: single-transfer Wishbone B4 classic master.
//
// Accepts one read or write command on a valid/ready handshake and issues it as a single
// classic cycle. It retries after RTY_I, aborts on ERR_I or on a wait-state timeout, and
// returns the read data and a status code on a valid/ready response port.
//
// Ports
//   CLK_I, RST_I          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_we, cmd_adr, cmd_dat, cmd_sel payload
//   rsp_valid/rsp_ready   response handshake; rsp_dat, rsp_status payload
//                         (00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT)
//   ADR_O .. BTE_O        Wishbone master outputs, all registered
//   DAT_I, ACK_I, ERR_I, RTY_I  Wishbone slave inputs, only sampled in the bus state
module wishbone_master #(
    parameter int unsigned WB_ADDR_W = 32,
    parameter int unsigned WB_DATA_W = 32,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [WB_ADDR_W-1:0]   cmd_adr,
    input  logic [WB_DATA_W-1:0]   cmd_dat,
    input  logic [WB_DATA_W/8-1:0] cmd_sel,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WB_DATA_W-1:0]   rsp_dat,
    output logic [1:0]             rsp_status,

    output logic [WB_ADDR_W-1:0]   ADR_O,
    output logic [WB_DATA_W-1:0]   DAT_O,
    output logic [WB_DATA_W/8-1:0] SEL_O,
    output logic                   WE_O,
    output logic                   STB_O,
    output logic                   CYC_O,
    output logic [2:0]             CTI_O,
    output logic [1:0]             BTE_O,
    input  logic [WB_DATA_W-1:0]   DAT_I,
    input  logic                   ACK_I,
    input  logic                   ERR_I,
    input  logic                   RTY_I
);

    localparam int unsigned SelW  = WB_DATA_W / 8;
    localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned RtyW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
    localparam logic [RtyW-1:0]  MaxRetry = RtyW'(MAX_RETRY);

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusErr     = 2'b01;
    localparam logic [1:0] StatusRtyExh  = 2'b10;
    localparam logic [1:0] StatusTimeout = 2'b11;

    typedef enum logic [1:0] {StIdle, StBus, StGap, StResp} state_e;

    state_e               state_q;

    // Latched command, replayed on every retry.
    logic                 we_q;
    logic [WB_ADDR_W-1:0] adr_q;
    logic [WB_DATA_W-1:0] dat_q;
    logic [SelW-1:0]      sel_q;

    logic [WaitW-1:0]     wait_q;
    logic [RtyW-1:0]      retry_q;

    // Registered outputs.
    logic                 cmd_ready_q;
    logic                 rsp_valid_q;
    logic [WB_DATA_W-1:0] rsp_dat_q;
    logic [1:0]           rsp_status_q;
    logic [WB_ADDR_W-1:0] adr_o_q;
    logic [WB_DATA_W-1:0] dat_o_q;
    logic [SelW-1:0]      sel_o_q;
    logic                 we_o_q;
    logic                 stb_o_q;
    logic                 cyc_o_q;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            wait_q       <= '0;
            retry_q      <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= StatusOk;
            adr_o_q      <= '0;
            dat_o_q      <= '0;
            sel_o_q      <= '0;
            we_o_q       <= 1'b0;
            stb_o_q      <= 1'b0;
            cyc_o_q      <= 1'b0;
        end else begin
            // Bus outputs are idle unless a branch below keeps the cycle running.
            adr_o_q <= '0;
            dat_o_q <= '0;
            sel_o_q <= '0;
            we_o_q  <= 1'b0;
            stb_o_q <= 1'b0;
            cyc_o_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // Also raises cmd_ready on the first edge after reset release.
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        we_q        <= cmd_we;
                        adr_q       <= cmd_adr;
                        dat_q       <= cmd_dat;
                        sel_q       <= cmd_sel;
                        retry_q     <= '0;
                        wait_q      <= '0;
                        adr_o_q     <= cmd_adr;
                        dat_o_q     <= cmd_we ? cmd_dat : '0;
                        sel_o_q     <= cmd_sel;
                        we_o_q      <= cmd_we;
                        stb_o_q     <= 1'b1;
                        cyc_o_q     <= 1'b1;
                        state_q     <= StBus;
                    end
                end

                StBus: begin
                    if (ERR_I) begin
                        rsp_status_q <= StatusErr;
                        rsp_dat_q    <= '0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StResp;
                    end else if (RTY_I) begin
                        if (retry_q < MaxRetry) begin
                            retry_q <= retry_q + RtyW'(1);
                            state_q <= StGap;
                        end else begin
                            rsp_status_q <= StatusRtyExh;
                            rsp_dat_q    <= '0;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= StResp;
                        end
                    end else if (ACK_I) begin
                        rsp_status_q <= StatusOk;
                        rsp_dat_q    <= we_q ? '0 : DAT_I;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StResp;
                    end else if (wait_q == WaitLast) begin
                        rsp_status_q <= StatusTimeout;
                        rsp_dat_q    <= '0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        wait_q  <= wait_q + WaitW'(1);
                        adr_o_q <= adr_q;
                        dat_o_q <= we_q ? dat_q : '0;
                        sel_o_q <= sel_q;
                        we_o_q  <= we_q;
                        stb_o_q <= 1'b1;
                        cyc_o_q <= 1'b1;
                    end
                end

                StGap: begin
                    // One idle cycle, then replay the same command.
                    wait_q  <= '0;
                    adr_o_q <= adr_q;
                    dat_o_q <= we_q ? dat_q : '0;
                    sel_o_q <= sel_q;
                    we_o_q  <= we_q;
                    stb_o_q <= 1'b1;
                    cyc_o_q <= 1'b1;
                    state_q <= StBus;
                end

                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;
    assign ADR_O      = adr_o_q;
    assign DAT_O      = dat_o_q;
    assign SEL_O      = sel_o_q;
    assign WE_O       = we_o_q;
    assign STB_O      = stb_o_q;
    assign CYC_O      = cyc_o_q;
    assign CTI_O      = 3'b000;
    assign BTE_O      = 2'b00;

endmodule

// File: tb/tb_wishbone_master.sv
// Testbench for wishbone_master: directed scenarios plus randomized transactions, each
// checked against a transaction-level model of the expected response and bus timing.
module tb_wishbone_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned MR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic          we_o, stb_o, cyc_o;
    logic [2:0]    cti_o;
    logic [1:0]    bte_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic          rty_i = 1'b0;

    always #5 clk = ~clk;

    wishbone_master #(
        .WB_ADDR_W(AW),
        .WB_DATA_W(DW),
        .TIMEOUT  (TO),
        .MAX_RETRY(MR)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_status(rsp_status),
        .ADR_O     (adr_o),
        .DAT_O     (dat_o),
        .SEL_O     (sel_o),
        .WE_O      (we_o),
        .STB_O     (stb_o),
        .CYC_O     (cyc_o),
        .CTI_O     (cti_o),
        .BTE_O     (bte_o),
        .DAT_I     (dat_i),
        .ACK_I     (ack_i),
        .ERR_I     (err_i),
        .RTY_I     (rty_i)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Slave script for the current transaction: per issue, which terminations
    // {ERR,RTY,ACK} to raise and after how many wait states. Mask 0 means never answer.
    logic [2:0]    terms [MR+1];
    int            waits [MR+1];
    logic [DW-1:0] rd_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel, input int hold);
        logic [1:0]    e_status;
        logic [DW-1:0] e_dat;
        int            e_issues, e_stb;
        int            cyc, idx, issue, stb_tot, bad, bad_hold;
        logic          prev_stb;
        logic [2:0]    term;
        logic [DW-1:0] held_dat;
        logic [1:0]    held_status;

        // Reference model: walk the slave script issue by issue.
        e_status = 2'b11;
        e_dat    = '0;
        e_issues = 0;
        e_stb    = 0;
        for (int k = 0; k <= int'(MR); k++) begin
            e_issues = k + 1;
            if (terms[k] == 3'b000 || waits[k] >= int'(TO)) begin
                e_stb += int'(TO);
                e_status = 2'b11;
                break;
            end
            e_stb += waits[k] + 1;
            if (terms[k][2]) begin
                e_status = 2'b01;
                break;
            end else if (terms[k][1]) begin
                if (k == int'(MR)) begin
                    e_status = 2'b10;
                    break;
                end
            end else begin
                e_status = 2'b00;
                e_dat    = we ? '0 : rd_data;
                break;
            end
        end

        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        step();
        cmd_valid = 1'b0;
        cmd_adr   = AW'($urandom);
        cmd_dat   = DW'($urandom);
        cmd_sel   = SW'($urandom);
        cmd_we    = ~we;

        cyc = 1; idx = 0; issue = 0; stb_tot = 0; bad = 0; prev_stb = 1'b0;
        while (!rsp_valid && cyc < 200) begin
            if (stb_o) begin
                if (!prev_stb) begin
                    issue++;
                    idx = 0;
                end
                stb_tot++;
                if (adr_o !== adr || sel_o !== sel || we_o !== we || cyc_o !== 1'b1 ||
                    dat_o !== (we ? dat : '0))
                    bad++;
                term = (issue <= int'(MR) + 1 && idx == waits[issue-1]) ? terms[issue-1]
                                                                        : 3'b000;
                {err_i, rty_i, ack_i} = term;
                dat_i = (term != 3'b000) ? rd_data : DW'($urandom);
                idx++;
            end else begin
                if (adr_o !== '0 || sel_o !== '0 || we_o !== 1'b0 || cyc_o !== 1'b0 ||
                    dat_o !== '0)
                    bad++;
                // Terminations outside the bus state must be ignored.
                {err_i, rty_i, ack_i} = 3'($urandom);
                dat_i = DW'($urandom);
            end
            if (cmd_ready !== 1'b0 || cti_o !== 3'b000 || bte_o !== 2'b00) bad++;
            prev_stb = stb_o;
            step();
            cyc++;
        end

        check({tag, " rsp_cycle"}, 64'(cyc), 64'(1 + e_stb + e_issues - 1));
        check({tag, " status"}, 64'(rsp_status), 64'(e_status));
        check({tag, " rsp_dat"}, 64'(rsp_dat), 64'(e_dat));
        check({tag, " issues"}, 64'(issue), 64'(e_issues));
        check({tag, " stb_cycles"}, 64'(stb_tot), 64'(e_stb));
        check({tag, " bus_fields"}, 64'(bad), 64'(0));

        held_dat    = rsp_dat;
        held_status = rsp_status;
        bad_hold    = 0;
        for (int h = 0; h < hold; h++) begin
            {err_i, rty_i, ack_i} = 3'($urandom);
            step();
            if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_status !== held_status ||
                cmd_ready !== 1'b0 || stb_o !== 1'b0 || cyc_o !== 1'b0)
                bad_hold++;
        end
        if (hold > 0) check({tag, " hold_stable"}, 64'(bad_hold), 64'(0));

        {err_i, rty_i, ack_i} = 3'b000;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, " rsp_done"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    endtask

    task automatic set_all(input logic [2:0] t, input int w);
        for (int k = 0; k <= int'(MR); k++) begin
            terms[k] = t;
            waits[k] = w;
        end
    endtask

    initial begin
        int r;
        int bad;

        set_all(3'b000, 0);
        rd_data = '0;

        // Reset state.
        #2;
        check("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_dat, rsp_status, stb_o, cyc_o,
                                    we_o}), 64'(0));
        check("reset_bus", 64'({adr_o, dat_o}), 64'(0));
        step();
        step();
        check("reset_held", 64'({cmd_ready, stb_o, cyc_o, sel_o, cti_o, bte_o}), 64'(0));
        #3;
        rst_n = 1'b1;
        step();
        check("ready_after_reset", 64'(cmd_ready), 64'(1));

        // Read, ACK in second bus cycle.
        set_all(3'b001, 1);
        rd_data = 32'hDEAD_BEEF;
        run_txn("read", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0);

        // Write.
        set_all(3'b001, 1);
        rd_data = 32'hFFFF_FFFF;
        run_txn("write", 1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 0);

        // Retry on every issue until exhausted.
        set_all(3'b010, 0);
        run_txn("retry", 1'b0, 32'h0000_0030, 32'h0, 4'hF, 0);

        // No termination at all.
        set_all(3'b000, 0);
        run_txn("timeout", 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hC, 0);

        // Termination on the last allowed wait state beats the timeout.
        set_all(3'b001, int'(TO) - 1);
        rd_data = 32'h0BAD_F00D;
        run_txn("ack_at_limit", 1'b0, 32'h0000_0050, 32'h0, 4'h1, 0);

        // ACK and ERR together, with response backpressure.
        set_all(3'b101, 0);
        run_txn("ack_err", 1'b0, 32'h0000_0060, 32'h0, 4'hF, 5);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k <= int'(MR); k++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      terms[k] = 3'b000;
                else if (r < 5)  terms[k] = 3'b010;
                else             terms[k] = 3'($urandom_range(1, 7));
                r = int'($urandom_range(0, 9));
                waits[k] = (r == 9) ? int'($urandom_range(TO - 2, TO + 1))
                                    : int'($urandom_range(0, 4));
            end
            rd_data = DW'($urandom);
            run_txn($sformatf("rand%0d", n), 1'($urandom), AW'($urandom), DW'($urandom),
                    SW'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a bus cycle.
        set_all(3'b000, 0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h0000_0070;
        cmd_dat   = 32'h5555_AAAA;
        cmd_sel   = 4'hF;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_bus_stb", 64'({stb_o, cyc_o}), 64'(2'b11));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_drop", 64'({stb_o, cyc_o, rsp_valid, cmd_ready}), 64'(0));
        #2;
        rst_n = 1'b1;
        step();
        check("ready_after_midreset", 64'(cmd_ready), 64'(1));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            {err_i, rty_i, ack_i} = 3'($urandom);
            step();
            if (rsp_valid !== 1'b0 || stb_o !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        check("no_rsp_after_reset", 64'(bad), 64'(0));
        {err_i, rty_i, ack_i} = 3'b000;

        set_all(3'b001, 0);
        rd_data = 32'hCAFE_0001;
        run_txn("post_reset", 1'b0, 32'h0000_0080, 32'h0, 4'hF, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
